// File: rtl/fir_out_collector.sv
// fir_out_collector: buffers 4-lane FIR output frames in a small FIFO and
// serializes each frame as one word per lane over a valid/ready link.
// Optional feature macro COLLECT_SUM_EN appends a fifth word per frame holding
// the saturated sum of the four lanes; with it undefined no sum logic exists.
module fir_out_collector #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LANE_W     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic [4*LANE_W-1:0]   lane_in,
  input  logic                  ser_ready,
  input  logic                  clear_ovf,
  output logic [LANE_W-1:0]     ser_out,
  output logic                  ser_valid,
  output logic [2:0]            ser_lane,
  output logic                  ser_last,
  output logic [4:0]            fifo_count,
  output logic                  overflow
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DepthC = 5'(FIFO_DEPTH);
`ifdef COLLECT_SUM_EN
  localparam logic [2:0]  LastLane = 3'd4;
`else
  localparam logic [2:0]  LastLane = 3'd3;
`endif

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e               state_q, state_d;
  logic [4*LANE_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [4:0]           count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [LANE_W-1:0]    out_q, out_d;
  logic [2:0]           lane_q, lane_d, lane_inc;
  logic                 last_q, last_d;
  logic                 full, empty, hs, pop, push, drop;
  logic [4*LANE_W-1:0]  head, next_head;

`ifdef COLLECT_SUM_EN
  // Sum of the four signed lanes at LANE_W+2 bits, clamped to the lane range.
  function automatic logic [LANE_W-1:0] sat_sum(input logic [4*LANE_W-1:0] f);
    logic signed [LANE_W+1:0] s;
    logic        [LANE_W-1:0] v;
    logic        [LANE_W-1:0] r;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      v = f[k*LANE_W +: LANE_W];
      s = s + $signed({{2{v[LANE_W-1]}}, v});
    end
    if (s > $signed({3'b000, {(LANE_W-1){1'b1}}})) begin
      r = {1'b0, {(LANE_W-1){1'b1}}};
    end else if (s < $signed({3'b111, {(LANE_W-1){1'b0}}})) begin
      r = {1'b1, {(LANE_W-1){1'b0}}};
    end else begin
      r = s[LANE_W-1:0];
    end
    return r;
  endfunction
`endif

  // Select the word for a given lane index out of a frame.
  function automatic logic [LANE_W-1:0] pick(input logic [4*LANE_W-1:0] f,
                                             input logic [2:0]          idx);
    logic [LANE_W-1:0] w;
    w = '0;
    case (idx)
      3'd0:    w = f[0*LANE_W +: LANE_W];
      3'd1:    w = f[1*LANE_W +: LANE_W];
      3'd2:    w = f[2*LANE_W +: LANE_W];
      3'd3:    w = f[3*LANE_W +: LANE_W];
`ifdef COLLECT_SUM_EN
      3'd4:    w = sat_sum(f);
`endif
      default: w = '0;
    endcase
    return w;
  endfunction

  assign ser_valid  = (state_q == StSend);
  assign ser_out    = out_q;
  assign ser_lane   = lane_q;
  assign ser_last   = last_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

  assign full       = (count_q == DepthC);
  assign empty      = (count_q == 5'd0);
  assign hs         = ser_valid & ser_ready;
  assign pop        = hs & last_q;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push       = clk_enable & (~full | pop);
  assign drop       = clk_enable & full & ~pop;
  assign lane_inc   = lane_q + 3'd1;
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;
  assign head       = mem_q[rd_ptr_q];
  // Frame following the head; bypass lane_in when it is being written right now.
  assign next_head  = (count_q > 5'd1) ? mem_q[rd_ptr_nxt] : lane_in;

  // Occupancy and sticky overflow next-state; a new drop beats clear_ovf.
  always_comb begin
    count_d = count_q + {4'b0, push} - {4'b0, pop};
    ovf_d   = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // FSM next-state and registered serializer outputs.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    lane_d  = lane_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StSend;
          out_d   = pick(head, 3'd0);
          lane_d  = 3'd0;
          last_d  = 1'b0;
        end
      end
      StSend: begin
        if (hs) begin
          if (!last_q) begin
            lane_d = lane_inc;
            out_d  = pick(head, lane_inc);
            last_d = (lane_inc == LastLane);
          end else if (count_d != 5'd0) begin
            // Back-to-back frame: restart at lane 0 without a bubble.
            lane_d = 3'd0;
            out_d  = pick(next_head, 3'd0);
            last_d = 1'b0;
          end else begin
            state_d = StIdle;
            lane_d  = 3'd0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= lane_in;
    end
  end

  // State, pointers, occupancy and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      out_q    <= '0;
      lane_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      out_q    <= out_d;
      lane_q   <= lane_d;
      last_q   <= last_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_collector.sv
// Testbench for fir_out_collector: scoreboard of expected serialized words,
// filled when frames are strobed in and drained by a handshake monitor.
module tb_fir_out_collector;

  localparam int LANE_W = 10;
  localparam int DEPTH  = 4;
`ifdef COLLECT_SUM_EN
  localparam bit         SumEn    = 1'b1;
  localparam logic [2:0] LastLane = 3'd4;
`else
  localparam bit         SumEn    = 1'b0;
  localparam logic [2:0] LastLane = 3'd3;
`endif

  logic                clk;
  logic                reset;
  logic                clk_enable;
  logic [4*LANE_W-1:0] lane_in;
  logic                ser_ready;
  logic                clear_ovf;
  logic [LANE_W-1:0]   ser_out;
  logic                ser_valid;
  logic [2:0]          ser_lane;
  logic                ser_last;
  logic [4:0]          fifo_count;
  logic                overflow;

  fir_out_collector #(
    .FIFO_DEPTH(DEPTH),
    .LANE_W    (LANE_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .lane_in   (lane_in),
    .ser_ready (ser_ready),
    .clear_ovf (clear_ovf),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_lane  (ser_lane),
    .ser_last  (ser_last),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]        lane;
    logic              last;
    logic [LANE_W-1:0] data;
  } word_t;

  word_t sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANE_W-1:0] sum_model(input int v0, v1, v2, v3);
    int s;
    int hi;
    int lo;
    hi = (1 << (LANE_W - 1)) - 1;
    lo = -(1 << (LANE_W - 1));
    s  = v0 + v1 + v2 + v3;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return LANE_W'(s);
  endfunction

  task automatic expect_frame(input int v0, v1, v2, v3);
    int    v[4];
    word_t w;
    v = '{v0, v1, v2, v3};
    for (int k = 0; k < 4; k++) begin
      w.lane = 3'(k);
      w.data = LANE_W'(v[k]);
      w.last = (k == 3) && !SumEn;
      sb_q.push_back(w);
    end
    if (SumEn) begin
      w.lane = 3'd4;
      w.data = sum_model(v0, v1, v2, v3);
      w.last = 1'b1;
      sb_q.push_back(w);
    end
  endtask

  // Present one frame for a single edge; accept says whether it should survive.
  task automatic strobe(input int v0, v1, v2, v3, input bit accept);
    int v[4];
    v = '{v0, v1, v2, v3};
    for (int k = 0; k < 4; k++) lane_in[k*LANE_W +: LANE_W] = LANE_W'(v[k]);
    clk_enable = 1'b1;
    @(posedge clk) #1;
    clk_enable = 1'b0;
    if (accept) expect_frame(v0, v1, v2, v3);
  endtask

  task automatic wait_lane(input string tag, input logic [2:0] lane, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk) #1;
      if (ser_valid && ser_lane == lane) begin
        found = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic drain(input string tag, input bit rnd_ready, input int budget);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < budget) begin
      @(posedge clk) #1;
      if (rnd_ready) ser_ready = 1'($urandom_range(0, 1));
      i++;
    end
    ser_ready = 1'b1;
    check_eq({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
    @(posedge clk) #1;
    check_eq({tag, "_count0"}, 32'(fifo_count), 32'd0);
    check_eq({tag, "_idle"}, 32'(ser_valid), 32'd0);
  endtask

  // Every accepted word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && ser_valid && ser_ready) begin
      check_eq("sb_has_word", 32'(sb_q.size() > 0), 32'd1);
      check_eq("count_nonzero", 32'(fifo_count != 5'd0), 32'd1);
      if (sb_q.size() > 0) begin
        word_t w;
        w = sb_q.pop_front();
        check_eq("ser_out", 32'(ser_out), 32'(w.data));
        check_eq("ser_lane", 32'(ser_lane), 32'(w.lane));
        check_eq("ser_last", 32'(ser_last), 32'(w.last));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANE_W-1:0] m3;
    m3 = LANE_W'(-3);

    reset      = 1'b1;
    clk_enable = 1'b0;
    lane_in    = '0;
    ser_ready  = 1'b1;
    clear_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(ser_valid), 32'd0);
    check_eq("rst_out", 32'(ser_out), 32'd0);
    check_eq("rst_lane", 32'(ser_lane), 32'd0);
    check_eq("rst_last", 32'(ser_last), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(posedge clk) #1;

    // Single frame and one-cycle latency.
    strobe(5, -3, 100, -512, 1'b1);
    check_eq("lat_count1", 32'(fifo_count), 32'd1);
    check_eq("lat_not_yet", 32'(ser_valid), 32'd0);
    @(posedge clk) #1;
    check_eq("lat_valid", 32'(ser_valid), 32'd1);
    check_eq("lat_lane0", 32'(ser_lane), 32'd0);
    drain("single", 1'b0, 50);

    // Backpressure held at lane 1.
    strobe(5, -3, 100, -512, 1'b1);
    wait_lane("bp_reach_lane1", 3'd1, 20);
    ser_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("bp_out", 32'(ser_out), 32'(m3));
      check_eq("bp_lane", 32'(ser_lane), 32'd1);
      check_eq("bp_valid", 32'(ser_valid), 32'd1);
    end
    @(posedge clk) #1;
    ser_ready = 1'b1;
    drain("bp", 1'b0, 50);

    // Overflow: five strobes into a stalled FIFO of four.
    ser_ready = 1'b0;
    for (int f = 1; f <= 4; f++) strobe(f, -f, 10 * f, -100, 1'b1);
    check_eq("ovf_before", 32'(overflow), 32'd0);
    strobe(77, 77, 77, 77, 1'b0);
    check_eq("ovf_count", 32'(fifo_count), 32'd4);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    @(posedge clk) #1;
    clear_ovf = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'd0);

    // Push coinciding with the last-word pop on a full FIFO.
    ser_ready = 1'b1;
    wait_lane("pp_reach_last", LastLane, 30);
    check_eq("pp_full", 32'(fifo_count), 32'd4);
    strobe(9, 8, 7, 6, 1'b1);
    check_eq("pp_count", 32'(fifo_count), 32'd4);
    check_eq("pp_no_ovf", 32'(overflow), 32'd0);
    drain("pp", 1'b0, 100);

    // Reset mid-frame discards everything.
    strobe(11, 22, 33, 44, 1'b1);
    strobe(55, 66, 77, 88, 1'b1);
    wait_lane("mr_reach_lane2", 3'd2, 20);
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk) #1;
    reset = 1'b0;
    check_eq("mr_valid", 32'(ser_valid), 32'd0);
    check_eq("mr_count", 32'(fifo_count), 32'd0);
    check_eq("mr_out", 32'(ser_out), 32'd0);
    check_eq("mr_lane", 32'(ser_lane), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mr_stays_idle", 32'(ser_valid), 32'd0);
    strobe(-1, 2, -3, 4, 1'b1);
    drain("mr_after", 1'b0, 50);

    // Saturation extremes (sum word only exists when the feature is built in).
    strobe(511, 511, 511, 511, 1'b1);
    strobe(-512, -512, -512, -512, 1'b1);
    strobe(100, -50, 7, -300, 1'b1);
    drain("sat", 1'b0, 100);

    // Random data with random backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < 3; f++) begin
        strobe(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
               int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512, 1'b1);
      end
      drain("rnd", 1'b1, 400);
    end
    check_eq("final_ovf", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
